// File: rtl/leaf_decoder.sv
// -----------------------------------------------------------------------------
// leaf_decoder
//
// Result-side consumer for the decision-tree classifier. Each one-cycle
// in_valid pulse carries a {level, path} verdict. The verdict is turned into a
// leaf index, mapped to a programmable class label, optionally timestamped,
// and queued in a small event FIFO. A downstream valid/ready consumer drains
// that FIFO. Events that arrive while the FIFO is full and not being popped
// are discarded and counted.
//
// Build option:
//   LEAF_DECODER_TS_EN  defined   -> event = {ts, leaf, class}, free-running
//                                    TS_WIDTH timestamp counter present
//                       undefined -> event = {leaf, class}, no timestamp logic
//
// Ports:
//   clk        in   sole clock
//   reset      in   asynchronous, active-high; clears all state
//   level      in   LW      depth at which the tree terminated
//   path       in   LW      branch bits taken, LSB = root decision
//   in_valid   in   1       qualifies level/path
//   tbl_we     in   1       class-table write strobe
//   tbl_addr   in   2*LW    leaf index to program
//   tbl_data   in   CW      class label to write
//   out_event  out  EW      registered head-of-FIFO event
//   out_valid  out  1       FIFO non-empty
//   out_ready  in   1       consumer accepts head when high with out_valid
//   drop_count out  DW      saturating count of refused events
//   dropped    out  1       sticky: at least one event dropped since reset
// -----------------------------------------------------------------------------
module leaf_decoder #(
    parameter int FEATURES    = 3,
    parameter int CLASS_WIDTH = 2,
    parameter int FIFO_DEPTH  = 4,
    parameter int TS_WIDTH    = 16,
    parameter int DROP_WIDTH  = 8,
    localparam int LW = $clog2(FEATURES),
`ifdef LEAF_DECODER_TS_EN
    localparam int EW = TS_WIDTH + 2*LW + CLASS_WIDTH
`else
    // TS_WIDTH stays in the expression so the parameter remains referenced.
    localparam int EW = 2*LW + CLASS_WIDTH + 0*TS_WIDTH
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LW-1:0]          level,
    input  logic [LW-1:0]          path,
    input  logic                   in_valid,
    input  logic                   tbl_we,
    input  logic [2*LW-1:0]        tbl_addr,
    input  logic [CLASS_WIDTH-1:0] tbl_data,
    output logic [EW-1:0]          out_event,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DROP_WIDTH-1:0]  drop_count,
    output logic                   dropped
);

    localparam int NLEAF = 1 << (2*LW);
    localparam int PW    = $clog2(FIFO_DEPTH);

    localparam logic [PW:0] CNT_FULL = FIFO_DEPTH[PW:0];
    localparam logic [PW:0] CNT_ONE  = {{PW{1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // Class table
    // -------------------------------------------------------------------------
    logic [CLASS_WIDTH-1:0] tbl_q [NLEAF];
    logic [2*LW-1:0]        leaf;
    logic [CLASS_WIDTH-1:0] leaf_cls;

    assign leaf     = {level, path};
    // Combinational read of the registered table: a same-cycle write to the
    // same leaf only lands on the edge, so the lookup sees the old label.
    assign leaf_cls = tbl_q[leaf];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NLEAF; i++) begin
                tbl_q[i] <= '0;
            end
        end else if (tbl_we) begin
            tbl_q[tbl_addr] <= tbl_data;
        end
    end

    // -------------------------------------------------------------------------
    // Event assembly (optional timestamp)
    // -------------------------------------------------------------------------
    logic [EW-1:0] ev_new;

`ifdef LEAF_DECODER_TS_EN
    logic [TS_WIDTH-1:0] ts_q;

    // Free-running; wraps from all-ones to zero without any flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign ev_new = {ts_q, leaf, leaf_cls};
`else
    assign ev_new = {leaf, leaf_cls};
`endif

    // -------------------------------------------------------------------------
    // Event FIFO
    // -------------------------------------------------------------------------
    logic [EW-1:0]         mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         rd_nxt;
    logic [PW:0]           count_q, count_d;
    logic [EW-1:0]         head_q, head_d;
    logic [DROP_WIDTH-1:0] drop_q, drop_d;
    logic                  dropped_q, dropped_d;
    logic                  full, pop, push, drop;

    assign full   = (count_q == CNT_FULL);
    assign pop    = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push   = in_valid && (!full || pop);
    assign drop   = in_valid && !push;
    assign rd_nxt = rd_ptr_q + 1'b1;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        head_d    = head_q;
        drop_d    = drop_q;
        dropped_d = dropped_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_nxt;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        // The head register holds what the read pointer will point at after
        // this edge. After a pop with two or more entries the successor is
        // already in memory; with one entry the only candidate is the event
        // being pushed right now. FIFO_DEPTH >= 2 guarantees a push into a
        // full FIFO (write slot == old head slot) never disturbs rd_nxt.
        if (pop) begin
            if (count_q > CNT_ONE) begin
                head_d = mem_q[rd_nxt];
            end else if (push) begin
                head_d = ev_new;
            end
        end else if (push && (count_q == '0)) begin
            head_d = ev_new;
        end

        if (drop) begin
            dropped_d = 1'b1;
            if (drop_q != '1) begin
                drop_d = drop_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= ev_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            head_q    <= '0;
            drop_q    <= '0;
            dropped_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            head_q    <= head_d;
            drop_q    <= drop_d;
            dropped_q <= dropped_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_event  = head_q;
    assign drop_count = drop_q;
    assign dropped    = dropped_q;

endmodule

// File: tb/tb_leaf_decoder.sv
module tb_leaf_decoder;

`ifdef LEAF_DECODER_TS_EN
    localparam int EW = 22;
`else
    localparam int EW = 6;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    level = '0;
    logic [1:0]    path = '0;
    logic          in_valid = 1'b0;
    logic          tbl_we = 1'b0;
    logic [3:0]    tbl_addr = '0;
    logic [1:0]    tbl_data = '0;
    logic [EW-1:0] out_event;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    drop_count;
    logic          dropped;

    leaf_decoder dut (
        .clk       (clk),
        .reset     (reset),
        .level     (level),
        .path      (path),
        .in_valid  (in_valid),
        .tbl_we    (tbl_we),
        .tbl_addr  (tbl_addr),
        .tbl_data  (tbl_data),
        .out_event (out_event),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    int            n_chk = 0;
    int            n_bad = 0;
    logic [15:0]   tb_ts = '0;
    logic [1:0]    tbl_m [16];
    logic [EW-1:0] q [$];
    int            drop_m = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [EW-1:0] mk_ev(input logic [15:0] ts, input logic [3:0] lf,
                                            input logic [1:0] c);
`ifdef LEAF_DECODER_TS_EN
        return {ts, lf, c};
`else
        return {lf, c} | {EW{ts[0] & 1'b0}};
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        tb_ts++;
    endtask

    // Called at a negedge: check outputs, drive one cycle, update the model.
    task automatic cyc(input logic iv, input logic [3:0] lf, input logic rdy,
                       input logic we, input logic [3:0] wa, input logic [1:0] wd);
        logic [EW-1:0] ev;
        bit            pop, push;
        chk("vld", out_valid, q.size() != 0);
        if (q.size() != 0) chk("head", out_event, q[0]);
        in_valid  = iv;
        level     = lf[3:2];
        path      = lf[1:0];
        out_ready = rdy;
        tbl_we    = we;
        tbl_addr  = wa;
        tbl_data  = wd;
        ev   = mk_ev(tb_ts, lf, tbl_m[lf]);
        pop  = (q.size() != 0) && rdy;
        push = iv && ((q.size() < 4) || pop);
        step();
        if (pop) void'(q.pop_front());
        if (push) q.push_back(ev);
        if (iv && !push && drop_m != 255) drop_m++;
        if (we) tbl_m[wa] = wd;
        in_valid = 1'b0;
        tbl_we   = 1'b0;
        chk("drop", drop_count, drop_m[7:0]);
        chk("sticky", dropped, drop_m != 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_vld", out_valid, 1'b0);
        chk("rst_ev", out_event, '0);
        chk("rst_drop", drop_count, 8'd0);
        chk("rst_stk", dropped, 1'b0);
        q.delete();
        drop_m = 0;
        for (int i = 0; i < 16; i++) tbl_m[i] = 2'd0;
        @(negedge clk);
        reset = 1'b0;
        tb_ts = '0;
    endtask

    initial begin
        logic [3:0]  exp_leaf [4];
        logic [15:0] t0;

        do_reset();

        // Program leaf 6 -> class 3, classify {level=1,path=2} at ts 10.
        cyc(0, 4'd0, 1, 1, 4'd6, 2'd3);
        for (int i = 0; i < 20 && tb_ts != 16'd10; i++) cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);
        cyc(1, 4'd6, 1, 0, 4'd0, 2'd0);
        chk("p_vld", out_valid, 1'b1);
        chk("p_ev", out_event, mk_ev(16'd10, 4'd6, 2'd3));
        cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);
        chk("p_once", out_valid, 1'b0);

        // Same-cycle write and lookup of leaf 5.
        cyc(1, 4'd5, 1, 1, 4'd5, 2'd2);
        chk("sc_old", out_event[1:0], 2'd0);
        cyc(1, 4'd5, 1, 0, 4'd0, 2'd0);
        chk("sc_new", out_event[1:0], 2'd2);
        cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);

        // Overflow: six pushes with no consumer.
        t0 = tb_ts;
        for (int i = 0; i < 6; i++) cyc(1, 4'(8 + i), 0, 0, 4'd0, 2'd0);
        chk("ov_cnt", drop_count, 8'd2);
        chk("ov_stk", dropped, 1'b1);
        for (int k = 0; k < 4; k++) begin
            chk("ov_order", out_event, mk_ev(t0 + 16'(k), 4'(8 + k), 2'd0));
            cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);
        end
        chk("ov_empty", out_valid, 1'b0);

        // Full FIFO with simultaneous push and pop for three cycles.
        for (int i = 0; i < 4; i++) cyc(1, 4'(12 + i), 0, 0, 4'd0, 2'd0);
        for (int i = 0; i < 3; i++) cyc(1, 4'(1 + i), 1, 0, 4'd0, 2'd0);
        chk("fp_nodrop", drop_count, 8'd2);
        exp_leaf[0] = 4'd15; exp_leaf[1] = 4'd1; exp_leaf[2] = 4'd2; exp_leaf[3] = 4'd3;
        for (int k = 0; k < 4; k++) begin
            chk("fp_order", out_event[5:2], exp_leaf[k]);
            cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);
        end
        chk("fp_empty", out_valid, 1'b0);

        // Timestamp wrap across an event pair.
        for (int i = 0; i < 70000 && tb_ts != 16'hFFFF; i++) step();
        cyc(1, 4'd9, 1, 0, 4'd0, 2'd0);
        chk("wrap_hi", out_event, mk_ev(16'hFFFF, 4'd9, 2'd0));
        cyc(1, 4'd10, 1, 0, 4'd0, 2'd0);
        chk("wrap_lo", out_event, mk_ev(16'h0000, 4'd10, 2'd0));
        cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);

        // 300 more drops saturate the counter.
        for (int i = 0; i < 304; i++) cyc(1, 4'd3, 0, 0, 4'd0, 2'd0);
        chk("sat_cnt", drop_count, 8'd255);
        chk("sat_stk", dropped, 1'b1);

        // Reset with three queued events; table is cleared too.
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 4'd6, 0, 0, 4'd0, 2'd0);
        chk("pre_rst", out_valid, 1'b1);
        do_reset();
        cyc(1, 4'd6, 1, 0, 4'd0, 2'd0);
        chk("post_rst", out_event, mk_ev(16'd0, 4'd6, 2'd0));
        cyc(0, 4'd0, 1, 0, 4'd0, 2'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/leaf_decoder.md
# leaf_decoder

Result-side consumer for the decision-tree classifier. It receives the `{level, path}` verdicts that the tree pulses out once per evaluated sample and maps each leaf to a programmable class label. It timestamps each event and buffers it in a small FIFO for a downstream valid/ready consumer, such as the spike-event serializer or the host readout. A drop counter records events lost to backpressure.

## Interface
Parameters:
- `FEATURES`, 3, tree depth; `LW = $clog2(FEATURES)` is the width of `level` and `path`.
- `CLASS_WIDTH`, 2, class label width.
- `FIFO_DEPTH`, 4, event FIFO entries; power of two, ≥2.
- `TS_WIDTH`, 16, timestamp counter width.
- `DROP_WIDTH`, 8, drop counter width.

Ports (`EW` = event width, defined under Configuration):
- `clk`  in  1  sole clock; all logic rises on it.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `level`  in  LW  depth at which the tree terminated.
- `path`  in  LW  branch bits taken, LSB = root decision.
- `in_valid`  in  1  one-cycle pulse qualifying `level`/`path`.
- `tbl_we`  in  1  class-table write strobe.
- `tbl_addr`  in  2*LW  leaf index to program.
- `tbl_data`  in  CLASS_WIDTH  class label to write.
- `out_event`  out  EW  head-of-FIFO event.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts head when high with `out_valid`.
- `drop_count`  out  DROP_WIDTH  saturating count of dropped events.
- `dropped`  out  1  sticky: at least one event dropped since reset.

## Operation
- Leaf index `leaf = {level, path}` (2*LW bits).
- Class table: 2^(2*LW) entries × CLASS_WIDTH flops, reset to 0.
  - `tbl_we` writes `tbl_data` at `tbl_addr` on the clock edge.
- Timestamp: free-running `TS_WIDTH` counter.
  - 0 after reset, +1 every cycle, wraps from all-ones to 0 silently.
- On `in_valid`, event = `{ts, leaf, class_table[leaf]}` sampled that cycle.
  - Table lookup uses the pre-write value if `tbl_we` targets the same leaf in the same cycle.
- FIFO: circular buffer with read/write pointers and occupancy count (0..FIFO_DEPTH).
  - Push when `in_valid` and (not full, or a pop occurs this cycle).
  - Pop when `out_valid && out_ready`.
- Push refused when full with no pop:
  - event discarded;
  - `drop_count` +1, saturating at all-ones;
  - `dropped` set to 1 and held until reset.
- Simultaneous push and pop:
  - when empty: push only (`out_valid` was 0);
  - when full: both occur, occupancy unchanged;
  - otherwise: occupancy unchanged, pointers both advance.
- `out_event` is registered FIFO head data; it is stable while `out_valid && !out_ready`.

## Timing
- Reset values: `out_valid`=0, `out_event`=0, `drop_count`=0, `dropped`=0, timestamp=0, pointers=0, table all 0.
- Latency: `in_valid` at edge N into an empty FIFO → `out_valid`=1 with that event after edge N (visible cycle N+1).
- Pop at edge M: next entry presented after edge M; if the FIFO empties, `out_valid`=0 after edge M.
- Sustained throughput: one event per cycle in and out.
- `drop_count`/`dropped` update on the edge of the refused push.
- Reset asserted mid-operation: FIFO flushed and table cleared immediately, with no clock required; in-flight event lost and not counted as dropped.

## Configuration
- `LEAF_DECODER_TS_EN`
  - Defined: timestamp counter present; event = `{ts, leaf, class}`, `EW = TS_WIDTH + 2*LW + CLASS_WIDTH`.
  - Undefined: no timestamp logic; event = `{leaf, class}`, `EW = 2*LW + CLASS_WIDTH`. All other behaviour identical.

## Test plan
Defaults; `LEAF_DECODER_TS_EN` defined unless stated.
- Program-and-classify:
  - stimulus: write leaf 0b0110 → class 3, then `in_valid` with level=1, path=2 at cycle 10 after reset, `out_ready`=1;
  - required: `out_event` = {ts=10, leaf=6, class=3}, `out_valid` high exactly one cycle.
- Same-cycle write/lookup:
  - stimulus: `tbl_we` to leaf 5 with class 2, concurrent with `in_valid` for leaf 5 (table 0);
  - required: event class 0; next lookup of leaf 5 gives class 2.
- Backpressure/overflow:
  - stimulus: `out_ready`=0, six back-to-back `in_valid`;
  - required: 4 buffered, `drop_count`=2, `dropped`=1; draining returns the first four events in order.
- Full with simultaneous push/pop:
  - stimulus: FIFO full, `out_ready`=1 and `in_valid`=1 for 3 cycles;
  - required: no drops, occupancy stays 4, output order preserved.
- Wrap and saturation:
  - timestamp all-ones then 0 across an event pair;
  - 300 drops → `drop_count`=255.
- Reset mid-stream and no-TS build:
  - stimulus: assert `reset` with 3 queued events;
  - required: `out_valid`=0 asynchronously, counters 0;
  - with `LEAF_DECODER_TS_EN` undefined: `out_event` width 6 and value {leaf, class}.
